uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- UART transmit-side framer and serializer. It is the transmit counterpart of the receive deserializer.
- Accepts a parallel word through a valid/ready handshake. Emits one frame LSB-first on tx_out: start bit (0), DATA_WIDTH data bits, optional parity bit, stop bit (1).
- Bit timing comes from an external baud tick: one pulse per bit period, from the shared baud generator.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (>= 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- tx_tick  input  1  one-clk pulse per bit period. Bit boundaries occur only on cycles where tx_tick=1.
- p_data  input  DATA_WIDTH  parallel word to send. Sampled only on accept.
- data_valid  input  1  p_data is valid. Must be held until accepted.
- par_type  input  1  0 = even parity, 1 = odd parity. Sampled on accept. Ignored when parity is compiled out.
- tx_ready  output  1  block can accept a word this cycle (combinational).
- tx_out  output  1  serial line. Idle = 1.
- busy  output  1  frame in progress, from accept until end of stop bit.
- tx_done  output  1  one-clk pulse when the stop bit completes.

Behaviour:
- Reset values: tx_out=1, busy=0, tx_done=0, state=IDLE, shift register=0, bit counter=0, latched parity=0.
- Reset mid-frame aborts the frame immediately. The line returns to 1 asynchronously.
- Accept = data_valid && tx_ready. On accept:
  - p_data is loaded into the shift register.
  - Parity bit is latched: XOR of p_data, inverted if par_type=1.
- tx_ready = (state==IDLE) || (state==STOP && tx_tick).
- data_valid while not tx_ready is ignored. Nothing is queued.
- FSM states: IDLE, SYNC, START, DATA, PARITY, STOP. All state changes are registered. tx_out is registered from the next state.
  - IDLE: tx_out=1, busy=0. On accept -> SYNC. A tx_tick in the accept cycle is not consumed.
  - SYNC: tx_out=1, busy=1. On tx_tick -> START. This aligns the start bit to a full bit period.
  - START: tx_out=0. On tx_tick -> DATA, with counter=0.
  - DATA: tx_out = shift register bit 0. On tx_tick: shift right by 1, counter+1. When counter==DATA_WIDTH-1 -> PARITY (if compiled in) else STOP.
  - PARITY: tx_out = latched parity bit. On tx_tick -> STOP.
  - STOP: tx_out=1. On tx_tick:
    - tx_done=1 for that cycle.
    - If accept occurs in the same cycle -> START directly. This gives back-to-back frames with no SYNC and no idle gap; busy stays 1.
    - Otherwise -> IDLE and busy=0.
- Each of START/DATA bits/PARITY/STOP lasts exactly one tick interval.
- Frame length: 1 + DATA_WIDTH + P + 1 tick intervals, where P = 1 if parity is compiled in, else 0. SYNC adds a variable 0..1 tick interval of idle before a non-back-to-back frame.
- Counter width is $clog2(DATA_WIDTH). Counter wraps to 0 on leaving DATA.
- p_data and par_type changes after accept have no effect on the frame in flight.
- tx_tick held high continuously is legal: every clk is then one bit period.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state exists. par_type selects even/odd. Frame = DATA_WIDTH+3 bits.
- Undefined:
  - No PARITY state, no parity register; par_type is unused.
  - DATA goes straight to STOP.
  - Frame = DATA_WIDTH+2 bits.

Test Plan:
- Parity, even: UART_TX_PARITY_EN defined, p_data=8'hA5, par_type=0, tx_tick every 16 clks, one accept -> line after SYNC: 0, 1,0,1,0,0,1,0,1, 0, 1. One tx_done pulse. busy low after stop.
- Parity, odd: same word, par_type=1 -> parity bit=1, other bits unchanged. Macro undefined -> 0,1,0,1,0,0,1,0,1,1 (10 bit periods), no parity bit.
- Back-to-back: data_valid held high with 8'h00 then 8'hFF -> second start bit immediately follows first stop bit. busy never drops between frames. Exactly 2 tx_done pulses.
- Busy rejection: pulse data_valid with 8'h3C during the DATA state of a frame -> ignored. tx_ready=0. Only the first word is transmitted.
- Reset mid-frame: assert rst during data bit 3 -> tx_out=1 and busy=0 immediately. After release, new word 8'h81 is sent correctly from START.
- Tick coincidence and continuous tick: accept in a cycle with tx_tick=1 -> SYNC still waits for the next tick. tx_tick tied to 1 -> each bit lasts exactly 1 clk.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmit framer/serializer: start bit, LSB-first data, optional parity, stop bit.
// Define UART_TX_PARITY_EN to include the parity bit (par_type: 0 = even, 1 = odd).
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_tick,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_type,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_t;
`endif

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]        r_cnt;
    logic                    w_accept;

`ifdef UART_TX_PARITY_EN
    logic                    r_parity;
    logic                    w_parity;
    assign w_parity = (^p_data) ^ par_type;
`else
    logic                    w_unused_par_type;
    assign w_unused_par_type = par_type;
`endif

    // A STOP-state tick also opens the handshake so the next start bit follows without a gap.
    assign tx_ready = (r_state == IDLE) || ((r_state == STOP) && tx_tick);
    assign w_accept = data_valid && tx_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift  <= p_data;
`ifdef UART_TX_PARITY_EN
                        r_parity <= w_parity;
`endif
                        r_state  <= SYNC;
                        busy     <= 1'b1;
                        tx_out   <= 1'b1;
                    end
                end
                SYNC: begin
                    if (tx_tick) begin
                        r_state <= START;
                        tx_out  <= 1'b0;
                    end
                end
                START: begin
                    if (tx_tick) begin
                        r_state <= DATA;
                        r_cnt   <= '0;
                        tx_out  <= r_shift[0];
                    end
                end
                DATA: begin
                    if (tx_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_cnt == LAST_BIT) begin
                            r_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
                            tx_out  <= r_parity;
`else
                            r_state <= STOP;
                            tx_out  <= 1'b1;
`endif
                        end else begin
                            r_cnt  <= r_cnt + CNT_W'(1);
                            tx_out <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tx_tick) begin
                        r_state <= STOP;
                        tx_out  <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tx_tick) begin
                        tx_done <= 1'b1;
                        if (w_accept) begin
                            r_shift  <= p_data;
`ifdef UART_TX_PARITY_EN
                            r_parity <= w_parity;
`endif
                            r_state  <= START;
                            tx_out   <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                            tx_out  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    tx_out  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: line samples at each tick packed LSB-first and compared
// with hand-computed frames (bit 0 = SYNC idle sample, then start, data, [parity], stop).
module tb_uart_tx_frame;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FLEN = DW + 3;
    localparam logic [31:0] EXP_A5_EVEN = 32'h0000_0A95;
    localparam logic [31:0] EXP_A5_ODD  = 32'h0000_0E95;
    localparam logic [31:0] EXP_B2B     = 32'h005F_E801;
    localparam logic [31:0] EXP_0F      = 32'h0000_083D;
    localparam logic [31:0] EXP_81      = 32'h0000_0A05;
`else
    localparam int FLEN = DW + 2;
    localparam logic [31:0] EXP_A5_EVEN = 32'h0000_0695;
    localparam logic [31:0] EXP_A5_ODD  = 32'h0000_0695;
    localparam logic [31:0] EXP_B2B     = 32'h001F_F401;
    localparam logic [31:0] EXP_0F      = 32'h0000_043D;
    localparam logic [31:0] EXP_81      = 32'h0000_0605;
`endif

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          tx_tick    = 1'b0;
    logic [DW-1:0] p_data     = '0;
    logic          data_valid = 1'b0;
    logic          par_type   = 1'b0;
    logic          tx_ready;
    logic          tx_out;
    logic          busy;
    logic          tx_done;

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;
    bit tick_cont  = 1'b0;
    int tick_phase = 0;

    uart_tx_frame #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_tick    (tx_tick),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_type   (par_type),
        .tx_ready   (tx_ready),
        .tx_out     (tx_out),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    // Baud tick: every 16th clk, or every clk in continuous mode; changes just after posedge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tick_cont) begin
                tx_tick = 1'b1;
            end else begin
                tick_phase = (tick_phase + 1) % 16;
                tx_tick    = (tick_phase == 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (tx_done === 1'b1) n_done++;
    endtask

    // Offer one word, then record tx_out on every tick cycle until `total` samples are taken.
    task automatic run_frame(input logic [7:0] data, input logic ptype,
                             input logic [7:0] next_data, input logic next_ptype,
                             input bit align_tick, input int total,
                             input int drop_at, input int pulse_at,
                             output logic [31:0] vec, output int first_at,
                             output int n_steps, output int busy_low);
        int n;
        int guard;
        bit pulsed;
        vec      = '0;
        n        = 0;
        guard    = 0;
        pulsed   = 1'b0;
        first_at = -1;
        n_steps  = 0;
        busy_low = 0;
        step();
        if (align_tick) begin
            while (tx_tick !== 1'b1 && guard < 100) begin
                step();
                guard++;
            end
        end
        p_data     = data;
        par_type   = ptype;
        data_valid = 1'b1;
        while (tx_ready !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        check("accept_wait_expired", 32'(guard >= 100), 32'd0);
        while (n < total && n_steps < 2000) begin
            step();
            n_steps++;
            if (n >= drop_at) data_valid = 1'b0;
            if (n_steps == 1) begin
                p_data   = next_data;
                par_type = next_ptype;
            end
            if (busy !== 1'b1) busy_low++;
            if (tx_tick === 1'b1) begin
                vec[n] = tx_out;
                if (n == 0) first_at = n_steps;
                n++;
            end
            if (n == pulse_at && !pulsed) begin
                pulsed     = 1'b1;
                p_data     = 8'h3C;
                data_valid = 1'b1;
                check("ready_low_in_data", tx_ready, 1'b0);
            end
        end
        check("samples_taken", n, total);
    endtask

    task automatic after_frame(input string tag);
        step();
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_line_idle"}, tx_out, 1'b1);
        step();
    endtask

    initial begin
        logic [31:0] vec;
        int first_at;
        int n_steps;
        int busy_low;
        int done0;

        repeat (3) @(negedge clk);
        check("rst_tx_out", tx_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_ready", tx_ready, 1'b1);
        rst = 1'b1;
        repeat (2) step();

        // Even parity A5; p_data/par_type scrambled right after accept.
        done0 = n_done;
        run_frame(8'hA5, 1'b0, 8'h5A, 1'b1, 1'b0, 1 + FLEN, 0, -1, vec, first_at, n_steps, busy_low);
        check("a5_even_line", vec, EXP_A5_EVEN);
        check("a5_even_busy_gap", busy_low, 0);
        after_frame("a5_even");
        check("a5_even_done_pulses", n_done - done0, 1);

        // Odd parity A5.
        done0 = n_done;
        run_frame(8'hA5, 1'b1, 8'h00, 1'b0, 1'b0, 1 + FLEN, 0, -1, vec, first_at, n_steps, busy_low);
        check("a5_odd_line", vec, EXP_A5_ODD);
        after_frame("a5_odd");
        check("a5_odd_done_pulses", n_done - done0, 1);

        // Back-to-back 00 then FF with data_valid held.
        done0 = n_done;
        run_frame(8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1 + 2 * FLEN, 1 + FLEN, -1,
                  vec, first_at, n_steps, busy_low);
        check("b2b_line", vec, EXP_B2B);
        check("b2b_busy_gap", busy_low, 0);
        after_frame("b2b");
        check("b2b_done_pulses", n_done - done0, 2);

        // Word offered mid-DATA must be dropped.
        done0 = n_done;
        run_frame(8'h0F, 1'b0, 8'h0F, 1'b0, 1'b0, 1 + FLEN, 0, 4, vec, first_at, n_steps, busy_low);
        check("reject_line", vec, EXP_0F);
        after_frame("reject");
        repeat (40) step();
        check("reject_still_idle", busy, 1'b0);
        check("reject_done_pulses", n_done - done0, 1);

        // Reset during data bit 3, then a clean frame.
        run_frame(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 5, 0, -1, vec, first_at, n_steps, busy_low);
        check("abort_partial_line", vec, 32'h0000_0001);
        step();
        check("abort_bit3_low", tx_out, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("abort_line_high", tx_out, 1'b1);
        check("abort_busy_low", busy, 1'b0);
        step();
        rst = 1'b1;
        step();
        done0 = n_done;
        run_frame(8'h81, 1'b0, 8'h7E, 1'b1, 1'b0, 1 + FLEN, 0, -1, vec, first_at, n_steps, busy_low);
        check("post_reset_81_line", vec, EXP_81);
        after_frame("post_reset");
        check("post_reset_done_pulses", n_done - done0, 1);

        // Accept coinciding with a tick: SYNC lasts a full 16-clk period.
        run_frame(8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 1 + FLEN, 0, -1, vec, first_at, n_steps, busy_low);
        check("coincide_sync_len", first_at, 16);
        check("coincide_line", vec, EXP_A5_EVEN);
        after_frame("coincide");

        // Continuous tick: one clk per bit.
        tick_cont = 1'b1;
        repeat (2) step();
        done0 = n_done;
        run_frame(8'hA5, 1'b1, 8'h00, 1'b0, 1'b1, 1 + FLEN, 0, -1, vec, first_at, n_steps, busy_low);
        check("cont_sync_len", first_at, 1);
        check("cont_frame_clks", n_steps, 1 + FLEN);
        check("cont_line", vec, EXP_A5_ODD);
        after_frame("cont");
        check("cont_done_pulses", n_done - done0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
